// File: rtl/fir_inverse_decoder.sv
// fir_inverse_decoder
//   Sequential inverse (deconvolution) filter for the 4-tap FIR filter
//   y[n] = 2^C0_SHIFT*x[n] + C1*x[n-1] + C2*x[n-2] + C3*x[n-3].
//   Recovers x[n] = (y[n] - C1*x[n-1] - C2*x[n-2] - C3*x[n-3]) / 2^C0_SHIFT
//   using one shared signed 8x8 multiplier over three MAC cycles.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : synchronous reset, active-low
//   y_in     : signed 16-bit filtered sample
//   y_valid  : y_in valid
//   y_ready  : decoder can accept y_in (high only while idle)
//   x_out    : signed 8-bit recovered sample
//   x_valid  : x_out / x_err valid
//   x_ready  : downstream accepts x_out
//   x_err    : x_out inexact (odd residual or saturated), qualified by x_valid
module fir_inverse_decoder #(
    parameter int C0_SHIFT = 1,
    parameter int C1       = 4,
    parameter int C2       = 4,
    parameter int C3       = 2,
    parameter int ACC_W    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] y_in,
    input  logic        y_valid,
    output logic        y_ready,
    output logic [7:0]  x_out,
    output logic        x_valid,
    input  logic        x_ready,
    output logic        x_err
);

    localparam logic signed [7:0] K1 = 8'(C1);
    localparam logic signed [7:0] K2 = 8'(C2);
    localparam logic signed [7:0] K3 = 8'(C3);

    localparam logic signed [ACC_W-1:0] QMAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] QMIN = -ACC_W'(128);
    // Bits shifted out by the divide; any of them set means the residual
    // was not a multiple of the tap-0 coefficient.
    localparam logic [ACC_W-1:0] FRAC_MASK = (ACC_W'(1) << C0_SHIFT) - ACC_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        MAC1,
        MAC2,
        MAC3,
        RESOLVE,
        OUT
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [7:0]       h1, h2, h3;

    // Shared multiplier operand selection
    logic signed [7:0]       mul_c;
    logic signed [7:0]       mul_h;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;

    always_comb begin
        mul_c = K1;
        mul_h = h1;
        case (state)
            MAC2: begin
                mul_c = K2;
                mul_h = h2;
            end
            MAC3: begin
                mul_c = K3;
                mul_h = h3;
            end
            default: begin
                mul_c = K1;
                mul_h = h1;
            end
        endcase
    end

    assign prod     = mul_c * mul_h;
    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};

    // Divide, inexactness detection and saturation
    logic signed [ACC_W-1:0] q;
    logic                    frac_nz;
    logic                    q_hi;
    logic                    q_lo;
    logic signed [7:0]       q_sat;

    assign q       = acc >>> C0_SHIFT;
    assign frac_nz = |(acc & FRAC_MASK);
    assign q_hi    = (q > QMAX);
    assign q_lo    = (q < QMIN);

    always_comb begin
        q_sat = q[7:0];
        if (q_hi) begin
            q_sat = 8'sh7f;
        end else if (q_lo) begin
            q_sat = 8'sh80;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            h1      <= '0;
            h2      <= '0;
            h3      <= '0;
            y_ready <= 1'b1;
            x_valid <= 1'b0;
            x_out   <= '0;
            x_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (y_valid) begin
                        acc     <= {{(ACC_W-16){y_in[15]}}, y_in};
                        y_ready <= 1'b0;
                        state   <= MAC1;
                    end
                end
                MAC1: begin
                    acc   <= acc - prod_ext;
                    state <= MAC2;
                end
                MAC2: begin
                    acc   <= acc - prod_ext;
                    state <= MAC3;
                end
                MAC3: begin
                    acc   <= acc - prod_ext;
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    x_out   <= q_sat;
                    x_err   <= frac_nz | q_hi | q_lo;
                    // History carries the saturated value so a bad sample
                    // does not derail the rest of the stream.
                    h3      <= h2;
                    h2      <= h1;
                    h1      <= q_sat;
                    x_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (x_ready) begin
                        x_valid <= 1'b0;
                        y_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    x_valid <= 1'b0;
                    y_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_inverse_decoder.sv
// Self-checking bench for fir_inverse_decoder with default coefficients
// (tap0=2, C1=4, C2=4, C3=2).
module tb_fir_inverse_decoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] y_in;
    logic        y_valid;
    logic        y_ready;
    logic [7:0]  x_out;
    logic        x_valid;
    logic        x_ready;
    logic        x_err;

    int errors = 0;
    int checks = 0;

    fir_inverse_decoder #(
        .C0_SHIFT(1),
        .C1(4),
        .C2(4),
        .C3(2),
        .ACC_W(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .y_in(y_in),
        .y_valid(y_valid),
        .y_ready(y_ready),
        .x_out(x_out),
        .x_valid(x_valid),
        .x_ready(x_ready),
        .x_err(x_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Offers one y sample, waits for the result, and completes the output
    // transfer. bp=1 randomises x_ready. lat = edges from accept to x_valid.
    // On timeout x/err come back as X so the caller's comparison fails.
    task automatic do_sample(input logic [15:0] y, input bit bp,
                             output logic [7:0] x, output logic e, output int lat);
        int n;
        x   = 'x;
        e   = 1'bx;
        lat = -1;
        n   = 0;
        while (!y_ready && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        if (!y_ready) begin
            $display("FAIL y_ready_timeout: y_ready=%b required 1", y_ready);
            return;
        end
        y_in    = y;
        y_valid = 1'b1;
        @(posedge clk);
        #1 y_valid = 1'b0;
        n = 0;
        while (!x_valid && n < 20) begin
            x_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1 n++;
        end
        if (!x_valid) return;
        lat = n;
        x   = x_out;
        e   = x_err;
        n   = 0;
        do begin
            x_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n > 40) x_ready = 1'b1;
            @(posedge clk);
            #1 n++;
        end while (x_ready == 1'b0);
        x_ready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (y_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_y_ready: got %b required 1", y_ready);
        end
        checks++;
        if (x_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_x_valid: got %b required 0", x_valid);
        end
        checks++;
        if (x_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_x_out: got %0d required 0", $signed(x_out));
        end
        checks++;
        if (x_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_x_err: got %b required 0", x_err);
        end
    endtask

    task automatic test_impulse();
        logic [15:0] ys [5] = '{16'd2, 16'd4, 16'd4, 16'd2, 16'd0};
        logic [7:0]  xs [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        logic [7:0]  x;
        logic        e;
        int          lat;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_sample(ys[i], 1'b0, x, e, lat);
            checks++;
            if (x !== xs[i]) begin
                errors++;
                $display("FAIL impulse_x[%0d]: got %0d required %0d", i, $signed(x), $signed(xs[i]));
            end
            checks++;
            if (e !== 1'b0) begin
                errors++;
                $display("FAIL impulse_err[%0d]: got %b required 0", i, e);
            end
        end
    endtask

    task automatic test_stream_latency();
        logic [15:0] ys [2] = '{16'd20, 16'd34};
        logic [7:0]  xs [2] = '{8'd10, 8'hfd};
        logic [7:0]  x;
        logic        e;
        int          lat;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            do_sample(ys[i], 1'b0, x, e, lat);
            checks++;
            if (x !== xs[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL stream_x[%0d]: got %0d err %b required %0d err 0", i, $signed(x), e, $signed(xs[i]));
            end
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL stream_latency[%0d]: got %0d required 4", i, lat);
            end
        end
    endtask

    task automatic test_errors();
        logic [7:0] x;
        logic       e;
        int         lat;
        do_reset();
        do_sample(16'd3, 1'b0, x, e, lat);
        checks++;
        if (x !== 8'd1 || e !== 1'b1) begin
            errors++;
            $display("FAIL odd_residual: got %0d err %b required 1 err 1", $signed(x), e);
        end
        do_reset();
        do_sample(16'd300, 1'b0, x, e, lat);
        checks++;
        if (x !== 8'd127 || e !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got %0d err %b required 127 err 1", $signed(x), e);
        end
        do_sample(16'd508, 1'b0, x, e, lat);
        checks++;
        if (x !== 8'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL after_saturate: got %0d err %b required 0 err 0", $signed(x), e);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        x_ready = 1'b0;
        y_in    = 16'd20;
        y_valid = 1'b1;
        @(posedge clk);
        #1 y_valid = 1'b0;
        n = 0;
        while (!x_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        y_in    = 16'd99;
        y_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (x_valid !== 1'b1 || x_out !== 8'd10 || x_err !== 1'b0 || y_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid %b x %0d err %b y_ready %b required 1 10 0 0",
                         i, x_valid, $signed(x_out), x_err, y_ready);
            end
            @(posedge clk);
            #1;
        end
        y_valid = 1'b0;
        x_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (x_valid !== 1'b0 || y_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid %b y_ready %b required 0 1", x_valid, y_ready);
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (x_valid) n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL bp_ignored_y: got %0d valid cycles required 0", n);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] x;
        logic       e;
        int         lat;
        int         n;
        do_reset();
        do_sample(16'd20, 1'b0, x, e, lat);
        checks++;
        if (x !== 8'd10) begin
            errors++;
            $display("FAIL mid_first: got %0d required 10", $signed(x));
        end
        y_in    = 16'd20;
        y_valid = 1'b1;
        @(posedge clk);
        #1 y_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (x_valid) n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL mid_aborted: got %0d valid cycles required 0", n);
        end
        do_sample(16'd20, 1'b0, x, e, lat);
        checks++;
        if (x !== 8'd10 || e !== 1'b0) begin
            errors++;
            $display("FAIL mid_history_cleared: got %0d err %b required 10 err 0", $signed(x), e);
        end
    endtask

    task automatic test_random_stream();
        logic signed [7:0]  hx [4];
        logic signed [15:0] y;
        logic [7:0]         x;
        logic               e;
        int                 lat;
        int                 bad;
        do_reset();
        for (int i = 0; i < 4; i++) hx[i] = '0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            hx[3] = hx[2];
            hx[2] = hx[1];
            hx[1] = hx[0];
            hx[0] = 8'($urandom_range(0, 255));
            y = 16'(2 * int'(hx[0]) + 4 * int'(hx[1]) + 4 * int'(hx[2]) + 2 * int'(hx[3]));
            do_sample(y, 1'b1, x, e, lat);
            checks++;
            if (x !== hx[0] || e !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got %0d err %b required %0d err 0", i, $signed(x), e, hx[0]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        y_in    = '0;
        y_valid = 1'b0;
        x_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_impulse();
        test_stream_latency();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
